// File: rtl/seq_det_fsm_if.sv
// ---------------------------------------------------------------------------
// seq_det_fsm_if
// Bus bundle between a serial pattern detector and its user.
//   en        : sample valid, din consumed only when high
//   din       : serial data bit
//   clr       : synchronous clear of detector state and match counter
//   pattern   : W-bit target, pattern[W-1] is the first bit received
//   y_mealy   : combinational hit on the final matching bit
//   y_moore   : registered, high while the detector sits in MATCH
//   match_cnt : saturating count of detected matches
//   state     : current matched-prefix length (debug)
// master drives the stream, slave is the detector.
// ---------------------------------------------------------------------------
interface seq_det_fsm_if #(
   parameter int W     = 4,
   parameter int CNT_W = 8
);
   localparam int SW = $clog2(W + 1);

   logic             en;
   logic             din;
   logic             clr;
   logic [W-1:0]     pattern;
   logic             y_mealy;
   logic             y_moore;
   logic [CNT_W-1:0] match_cnt;
   logic [SW-1:0]    state;

   modport master (
      output en, din, clr, pattern,
      input  y_mealy, y_moore, match_cnt, state
   );

   modport slave (
      input  en, din, clr, pattern,
      output y_mealy, y_moore, match_cnt, state
   );
endinterface

// File: rtl/seq_det_fsm.sv
// ---------------------------------------------------------------------------
// seq_det_fsm
// Runtime-programmable W-bit serial pattern detector.
//   clk   : rising-edge system clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_det_fsm_if slave modport (en, din, clr, pattern in;
//           y_mealy, y_moore, match_cnt, state out)
// The state is the length of the longest pattern prefix that is a suffix of
// the consumed stream. The fallback after a mismatch is recomputed each cycle
// directly from the pattern, so the pattern can be reprogrammed without any
// precomputed failure table.
// ---------------------------------------------------------------------------
module seq_det_fsm #(
   parameter int W       = 4,
   parameter bit OVERLAP = 1'b1,
   parameter int CNT_W   = 8
) (
   input logic          clk,
   input logic          rst_n,
   seq_det_fsm_if.slave bus
);
   localparam int            SW    = $clog2(W + 1);
   localparam int            TW    = W + 1;
   localparam logic [SW-1:0] EMPTY = '0;
   localparam logic [SW-1:0] MATCH = SW'(W);

   logic [SW-1:0]    state_q;
   logic             moore_q;
   logic [CNT_W-1:0] cnt_q;

   logic [SW-1:0]    base;
   logic [SW-1:0]    next_state;
   logic [TW-1:0]    hist_din;
   logic [TW-1:0]    mask;
   logic [TW-1:0]    prefix;
   logic             hit;

   // Next-state search: try every candidate length j and keep the largest
   // whose pattern prefix equals the tail of (matched prefix, din).
   always_comb begin
      // NOTE: every combinational output gets a default before the loop so no
      // path leaves it unassigned and no latch is inferred.
      next_state = EMPTY;
      mask       = '0;
      prefix     = '0;
      // Without overlap a completed match restarts the search from empty.
      base = (state_q == MATCH && !OVERLAP) ? EMPTY : state_q;
      // The matched prefix is the top 'base' bits of the pattern; append din.
      hist_din = (({1'b0, bus.pattern} >> (MATCH - base)) << 1) | {{W{1'b0}}, bus.din};
      for (int j = 1; j <= W; j++) begin
         mask   = TW'((1 << j) - 1);
         prefix = {1'b0, bus.pattern} >> (W - j);
         if ((j <= int'(base) + 1) && ((hist_din & mask) == prefix)) begin
            next_state = SW'(j);
         end
      end
   end

   assign hit = (next_state == MATCH);

   // NOTE: state registers use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         moore_q <= 1'b0;
         cnt_q   <= '0;
      end else if (bus.clr) begin
         state_q <= EMPTY;
         moore_q <= 1'b0;
         cnt_q   <= '0;
      end else if (bus.en) begin
         state_q <= next_state;
         moore_q <= hit;
         // Saturate at all-ones instead of wrapping.
         if (hit && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // rst_n gates the Mealy output so it is quiet throughout reset.
   assign bus.y_mealy   = rst_n & bus.en & ~bus.clr & hit;
   assign bus.y_moore   = moore_q;
   assign bus.match_cnt = cnt_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_seq_det_fsm.sv
// ---------------------------------------------------------------------------
// tb_seq_det_fsm
// Drives three detector instances with one shared stream:
//   idx 0 : OVERLAP=1, CNT_W=8
//   idx 1 : OVERLAP=0, CNT_W=8
//   idx 2 : OVERLAP=1, CNT_W=2 (saturation)
// The reference model keeps the raw consumed bit history and searches it for
// the longest suffix that is a pattern prefix.
// ---------------------------------------------------------------------------
module tb_seq_det_fsm;
   localparam int W = 4;

   logic clk;
   logic rst_n;
   logic [W-1:0] pat;

   int n_cmp;
   int n_fail;

   // Reference model state, one entry per instance.
   int unsigned hist     [3];
   int          hist_len [3];
   int          exp_state[3];
   int          exp_cnt  [3];
   int          exp_moore[3];
   int          exp_mealy[3];
   bit          ovl      [3];
   int          cap      [3];

   seq_det_fsm_if #(.W(W), .CNT_W(8)) if_ov  ();
   seq_det_fsm_if #(.W(W), .CNT_W(8)) if_no  ();
   seq_det_fsm_if #(.W(W), .CNT_W(2)) if_sat ();

   seq_det_fsm #(.W(W), .OVERLAP(1'b1), .CNT_W(8)) dut_ov  (.clk(clk), .rst_n(rst_n), .bus(if_ov));
   seq_det_fsm #(.W(W), .OVERLAP(1'b0), .CNT_W(8)) dut_no  (.clk(clk), .rst_n(rst_n), .bus(if_no));
   seq_det_fsm #(.W(W), .OVERLAP(1'b1), .CNT_W(2)) dut_sat (.clk(clk), .rst_n(rst_n), .bus(if_sat));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Longest j <= W such that the last j history bits equal the first j
   // pattern bits.
   function automatic int longest(input int unsigned h, input int len, input logic [W-1:0] p);
      int top;
      top = (len < W) ? len : W;
      for (int j = top; j > 0; j--) begin
         if ((h & ((32'd1 << j) - 32'd1)) == 32'(p >> (W - j))) return j;
      end
      return 0;
   endfunction

   function automatic int pred(input int i, input bit d);
      int unsigned h;
      int len;
      h   = (hist[i] << 1) | 32'(d);
      len = (hist_len[i] + 1 > 16) ? 16 : hist_len[i] + 1;
      return longest(h, len, pat);
   endfunction

   task automatic model_reset(input int i);
      hist[i]      = 0;
      hist_len[i]  = 0;
      exp_state[i] = 0;
      exp_cnt[i]   = 0;
      exp_moore[i] = 0;
   endtask

   task automatic model_commit(input int i, input bit e, input bit d, input bit c);
      int s;
      if (c) begin
         model_reset(i);
      end else if (e) begin
         s = pred(i, d);
         if (s == W && exp_cnt[i] < cap[i]) exp_cnt[i]++;
         if (s == W && !ovl[i]) begin
            hist[i]     = 0;
            hist_len[i] = 0;
         end else begin
            hist[i]     = (hist[i] << 1) | 32'(d);
            hist_len[i] = (hist_len[i] + 1 > 16) ? 16 : hist_len[i] + 1;
         end
         exp_state[i] = s;
         exp_moore[i] = (s == W) ? 1 : 0;
      end
   endtask

   task automatic drive(input bit e, input bit d, input bit c);
      if_ov.en  = e; if_ov.din  = d; if_ov.clr  = c; if_ov.pattern  = pat;
      if_no.en  = e; if_no.din  = d; if_no.clr  = c; if_no.pattern  = pat;
      if_sat.en = e; if_sat.din = d; if_sat.clr = c; if_sat.pattern = pat;
   endtask

   task automatic check_mealy();
      check("mealy_ov",  32'(if_ov.y_mealy),  exp_mealy[0]);
      check("mealy_no",  32'(if_no.y_mealy),  exp_mealy[1]);
      check("mealy_sat", 32'(if_sat.y_mealy), exp_mealy[2]);
   endtask

   task automatic check_regs();
      check("state_ov",  32'(if_ov.state),      exp_state[0]);
      check("moore_ov",  32'(if_ov.y_moore),    exp_moore[0]);
      check("cnt_ov",    32'(if_ov.match_cnt),  exp_cnt[0]);
      check("state_no",  32'(if_no.state),      exp_state[1]);
      check("moore_no",  32'(if_no.y_moore),    exp_moore[1]);
      check("cnt_no",    32'(if_no.match_cnt),  exp_cnt[1]);
      check("state_sat", 32'(if_sat.state),     exp_state[2]);
      check("moore_sat", 32'(if_sat.y_moore),   exp_moore[2]);
      check("cnt_sat",   32'(if_sat.match_cnt), exp_cnt[2]);
   endtask

   // Called just after a rising edge: drive, check Mealy at the falling edge,
   // then check registered outputs just after the next rising edge.
   task automatic step(input bit e, input bit d, input bit c);
      drive(e, d, c);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         exp_mealy[i] = (e && !c && pred(i, d) == W) ? 1 : 0;
      end
      check_mealy();
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) model_commit(i, e, d, c);
      check_regs();
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      drive(1'b1, 1'b1, 1'b0);
      #1;
      for (int i = 0; i < 3; i++) begin
         model_reset(i);
         exp_mealy[i] = 0;
      end
      check_mealy();
      check_regs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic load_pattern(input logic [W-1:0] p);
      pat = p;
      step(1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [6:0] s1;
      logic [3:0] s4;
      n_cmp  = 0;
      n_fail = 0;
      ovl[0] = 1'b1; ovl[1] = 1'b0; ovl[2] = 1'b1;
      cap[0] = 255;  cap[1] = 255;  cap[2] = 3;
      for (int i = 0; i < 3; i++) begin
         model_reset(i);
         exp_mealy[i] = 0;
      end

      // Reset state.
      rst_n = 1'b0;
      pat   = '0;
      drive(1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check_mealy();
      check_regs();
      rst_n = 1'b1;

      // Pattern 1011 on stream 1011011.
      load_pattern(4'b1011);
      s1 = 7'b1011011;
      for (int k = 6; k >= 0; k--) step(1'b1, s1[k], 1'b0);
      check("tp1_cnt_ov", 32'(if_ov.match_cnt), 2);
      check("tp1_cnt_no", 32'(if_no.match_cnt), 1);
      check("tp1_state_no", 32'(if_no.state), 1);

      // Pattern 1111, six ones.
      load_pattern(4'b1111);
      for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b0);
      check("tp2_cnt_ov", 32'(if_ov.match_cnt), 3);
      check("tp2_state_ov", 32'(if_ov.state), 4);
      check("tp2_cnt_no", 32'(if_no.match_cnt), 1);
      check("tp2_state_no", 32'(if_no.state), 2);

      // Eight ones, saturating 2-bit counter, then clear.
      step(1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0);
      check("tp3_cnt_ov", 32'(if_ov.match_cnt), 5);
      check("tp3_cnt_sat", 32'(if_sat.match_cnt), 3);
      step(1'b0, 1'b1, 1'b1);
      check("tp3_clr_cnt_sat", 32'(if_sat.match_cnt), 0);
      check("tp3_clr_state_sat", 32'(if_sat.state), 0);

      // 1011 with idle cycles (din toggling) between bits, trailing idles.
      load_pattern(4'b1011);
      s4 = 4'b1011;
      for (int k = 3; k >= 0; k--) begin
         step(1'b1, s4[k], 1'b0);
         step(1'b0, 1'b1, 1'b0);
         step(1'b0, 1'b0, 1'b0);
      end
      check("tp4_cnt_ov", 32'(if_ov.match_cnt), 1);
      check("tp4_moore_hold", 32'(if_ov.y_moore), 1);

      // Reset mid-sequence, then clr colliding with a completing bit.
      load_pattern(4'b1011);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      pulse_reset();
      step(1'b1, 1'b1, 1'b0);
      check("tp5_state_after_rst", 32'(if_ov.state), 1);
      check("tp5_cnt_after_rst", 32'(if_ov.match_cnt), 0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      check("tp5_clr_cnt", 32'(if_ov.match_cnt), 0);

      // Randomized patterns and streams against the model.
      for (int r = 0; r < 8; r++) begin
         load_pattern(4'($urandom_range(0, 15)));
         for (int k = 0; k < 60; k++) begin
            step(($urandom % 4) != 0, 1'($urandom % 2), ($urandom % 30) == 0);
         end
         if (r == 4) pulse_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/seq_det_fsm.md
# seq_det_fsm

Parametrised serial pattern detector built as a multi-segment FSM: state register, next-state logic, Mealy output and Moore output. It detects a runtime-programmable W-bit pattern on a 1-bit stream, with selectable overlapping or non-overlapping detection, a sample-enable, a synchronous clear and a saturating match counter. It sits behind any serial receiver that needs frame, sync-word or flag detection.

## Interface
- W, 4: pattern length in bits, legal range 2..16.
- OVERLAP, 1: 1 means a match may reuse trailing bits of the previous match; 0 means detection restarts from empty after each match.
- CNT_W, 8: match counter width, legal range ≥1.
- SW: localparam, $clog2(W+1), the state register width.
- clk  input  1  system clock; all state updates occur on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  sample valid; din is consumed only in cycles where en=1.
- din  input  1  serial data bit.
- clr  input  1  synchronous clear of state and counter; takes priority over en.
- pattern  input  W  target pattern. pattern[W-1] is the first bit received and pattern[0] the last.
- y_mealy  output  1  combinational; high in the cycle the final matching bit is presented.
- y_moore  output  1  registered; high while the FSM is in the MATCH state.
- match_cnt  output  CNT_W  number of matches detected, saturating.
- state  output  SW  current state, for debug.

## Operation
- State S ∈ {0..W}. S=k means the last k consumed bits equal the first k pattern bits (pattern[W-1] down to pattern[W-k]). S=W is MATCH.
- Next-state function, applied when en=1 and clr=0:
  - Form the string (matched prefix of length k, then din).
  - S_next is the largest j ≤ W such that the first j pattern bits equal the last j bits of that string (KMP-style fallback).
  - This is computed combinationally from pattern; no stored failure table.
- From S=W:
  - OVERLAP=1: the fallback runs over the full matched pattern plus din, so S_next can be up to W again.
  - OVERLAP=0: S_next is computed as if from S=0.
- When en=0 and clr=0: S holds and din is ignored.
- When clr=1: S_next=0 and match_cnt becomes 0 regardless of en/din.
- y_mealy = en & ~clr & (S_next==W).
- y_moore = (S==W). It holds while en=0.
- match_cnt increments by 1 on every cycle with y_mealy=1. It saturates at 2^CNT_W-1 and never wraps.
- pattern may change only while clr=1 or en=0, followed by a clr pulse. Transitions always use the current pattern value; no result is guaranteed across an unguarded change.

## Timing
- Reset: asserting rst_n=0 immediately forces S=0, y_moore=0, match_cnt=0 and state=0. y_mealy=0 while rst_n=0.
- Reset asserted mid-sequence discards the partial match. The first sample after deassertion is compared from S=0.
- y_mealy has zero-cycle latency from the final din bit and is combinational from en, din, clr and pattern.
- y_moore and the match_cnt update follow the final bit by 1 clock.
- Back-to-back matches (overlap, e.g. pattern all ones): y_mealy stays high on consecutive enabled cycles, and y_moore stays high continuously.
- clr in the same cycle as the final matching bit: no match is signalled and the counter ends at 0.
- The saturated counter stays at all-ones until clr or reset.

## Test plan
- W=4, pattern=1011, OVERLAP=1, en=1, din=1,0,1,1,0,1,1 → y_mealy high on bits 4 and 7, y_moore high the cycle after each, match_cnt=2.
- Same stream with OVERLAP=0 → y_mealy only on bit 4; state=1 after bit 7; match_cnt=1.
- pattern=1111, six consecutive 1s → OVERLAP=1: matches on bits 4, 5 and 6, match_cnt=3. OVERLAP=0: match on bit 4 only, final state=2, match_cnt=1.
- Stream 1,0,1,1 with en=0 cycles inserted between bits, and din toggled during those cycles → exactly one match, on the last enabled bit. state is unchanged across en=0 cycles; y_moore holds through trailing en=0.
- CNT_W=2, pattern=1111, OVERLAP=1, eight consecutive 1s → 5 matches, match_cnt saturates at 3. A following clr pulse → match_cnt=0, state=0.
- rst_n pulsed low after din=1,0,1 of pattern 1011, then din=1 → no match and state=1. clr asserted together with a completing bit → y_mealy=0 and match_cnt=0.
